// File: rtl/run_controller_pkg.sv
// run_ctrl_pkg: shared types and helpers for the run/completion controller.
//   state_t   - controller state, fixed 3-bit encoding
//   CNT_W_DEF - default counter width
//   res_lo()  - low bit index of result word idx in a packed result bus
package run_ctrl_pkg;

   typedef enum logic [2:0] {
      HOLD    = 3'd0,
      RUN     = 3'd1,
      DRAIN   = 3'd2,
      DONE    = 3'd3,
      TIMEOUT = 3'd4
   } state_t;

   localparam int CNT_W_DEF = 16;

   function automatic int res_lo(input int idx, input int xlen);
      return idx * xlen;
   endfunction

endpackage

// File: rtl/run_controller_if.sv
// run_controller_if: core-side signals of the run controller.
//   master - driven by the core/bench: fetch_valid, fetch_complete, pc,
//            result_in, restart; observes status outputs
//   slave  - the controller: core_reset, done, timed_out, cycle_count,
//            instr_count, last_pc, results
interface run_controller_if
   import run_ctrl_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int NUM_RESULTS = 2,
   parameter int CNT_W       = CNT_W_DEF
);
   logic                          fetch_valid;
   logic                          fetch_complete;
   logic [XLEN-1:0]               pc;
   logic [NUM_RESULTS*XLEN-1:0]   result_in;
   logic                          restart;
   logic                          core_reset;
   logic                          done;
   logic                          timed_out;
   logic [CNT_W-1:0]              cycle_count;
   logic [CNT_W-1:0]              instr_count;
   logic [XLEN-1:0]               last_pc;
   logic [NUM_RESULTS*XLEN-1:0]   results;

   modport master (
      output fetch_valid, fetch_complete, pc, result_in, restart,
      input  core_reset, done, timed_out, cycle_count, instr_count, last_pc, results
   );

   modport slave (
      input  fetch_valid, fetch_complete, pc, result_in, restart,
      output core_reset, done, timed_out, cycle_count, instr_count, last_pc, results
   );
endinterface

// File: rtl/run_controller_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
//   clk, reset (async, active-high) - clock / clear to 0
//   clr - synchronous clear (wins over inc)
//   inc - increment enable
//   q   - count value
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                q <= '0;
      else if (clr)             q <= '0;
      else if (inc && q != '1)  q <= q + 1'b1;
   end
endmodule

// File: rtl/run_controller.sv
// run_controller: stretches the core reset, counts run cycles and fetched
// instructions, waits for fetch_complete, drains, then snapshots results.
// A watchdog in RUN flags programs that never complete.
//   clk, reset - system clock, async active-high reset
//   bus        - run_controller_if.slave (core handshake + status outputs)
module run_controller
   import run_ctrl_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int NUM_RESULTS    = 2,
   parameter int RESET_CYCLES   = 10,
   parameter int DRAIN_CYCLES   = 10,
   parameter int TIMEOUT_CYCLES = 100,
   parameter int CNT_W          = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   run_controller_if.slave    bus
);
   state_t r_state, w_next;

   logic                        w_hold_inc, w_hold_clr, w_drain_inc, w_drain_clr;
   logic                        w_cyc_inc, w_instr_inc, w_cnt_clr, w_cap_pc, w_cap_res;
   logic [CNT_W-1:0]            w_hold_q, w_drain_q, w_cyc_q, w_instr_q;
   logic                        w_hold_last, w_drain_last, w_tmo;
   logic [XLEN-1:0]             r_last_pc;
   logic [NUM_RESULTS*XLEN-1:0] r_results;

   sat_counter #(.W(CNT_W)) u_hold_cnt (
      .clk(clk), .reset(reset), .clr(w_hold_clr | w_cnt_clr), .inc(w_hold_inc), .q(w_hold_q));
   // Separate drain timer keeps cycle_count a pure RUN+DRAIN total.
   sat_counter #(.W(CNT_W)) u_drain_cnt (
      .clk(clk), .reset(reset), .clr(w_drain_clr | w_cnt_clr), .inc(w_drain_inc), .q(w_drain_q));
   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk(clk), .reset(reset), .clr(w_cnt_clr), .inc(w_cyc_inc), .q(w_cyc_q));
   sat_counter #(.W(CNT_W)) u_instr_cnt (
      .clk(clk), .reset(reset), .clr(w_cnt_clr), .inc(w_instr_inc), .q(w_instr_q));

   assign w_hold_last  = (w_hold_q == CNT_W'(RESET_CYCLES - 1));
   // With no drain window the DRAIN state is never entered.
   assign w_drain_last = (DRAIN_CYCLES == 0) || (w_drain_q == CNT_W'(DRAIN_CYCLES - 1));
   assign w_tmo        = (w_cyc_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= HOLD;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_hold_inc  = 1'b0;
      w_hold_clr  = 1'b0;
      w_drain_inc = 1'b0;
      w_drain_clr = 1'b0;
      w_cyc_inc   = 1'b0;
      w_instr_inc = 1'b0;
      w_cnt_clr   = 1'b0;
      w_cap_pc    = 1'b0;
      w_cap_res   = 1'b0;
      case (r_state)
         HOLD: begin
            w_hold_inc = 1'b1;
            if (w_hold_last) begin
               w_next     = RUN;
               w_hold_clr = 1'b1;
            end
         end
         RUN: begin
            w_cyc_inc   = 1'b1;
            w_instr_inc = bus.fetch_valid;
            // Completion beats the watchdog on the same edge.
            if (bus.fetch_complete) begin
               w_cap_pc = 1'b1;
               if (DRAIN_CYCLES == 0) begin
                  w_next    = DONE;
                  w_cap_res = 1'b1;
               end else begin
                  w_next = DRAIN;
               end
            end else if (w_tmo) begin
               w_cap_pc = 1'b1;
               w_next   = TIMEOUT;
            end
         end
         DRAIN: begin
            w_cyc_inc   = 1'b1;
            w_drain_inc = 1'b1;
            if (w_drain_last) begin
               w_next      = DONE;
               w_cap_res   = 1'b1;
               w_drain_clr = 1'b1;
            end
         end
         DONE, TIMEOUT: begin
            if (bus.restart) begin
               w_next    = HOLD;
               w_cnt_clr = 1'b1;
            end
         end
         default: w_next = HOLD;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last_pc <= '0;
         r_results <= '0;
      end else if (w_cnt_clr) begin
         r_last_pc <= '0;
         r_results <= '0;
      end else begin
         if (w_cap_pc) r_last_pc <= bus.pc;
         if (w_cap_res) begin
            for (int i = 0; i < NUM_RESULTS; i++)
               r_results[res_lo(i, XLEN) +: XLEN] <= bus.result_in[res_lo(i, XLEN) +: XLEN];
         end
      end
   end

   assign bus.core_reset  = (r_state == HOLD);
   assign bus.done        = (r_state == DONE);
   assign bus.timed_out   = (r_state == TIMEOUT);
   assign bus.cycle_count = w_cyc_q;
   assign bus.instr_count = w_instr_q;
   assign bus.last_pc     = r_last_pc;
   assign bus.results     = r_results;
endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: directed + randomized bench for run_controller.
// Expected values come from a scenario-level model: count of fetch pulses
// issued on RUN edges, completion edge k, PC driven on the deciding edge,
// result_in on the last drain edge.
module tb_run_controller;
   import run_ctrl_pkg::*;

   localparam int XLEN = 32, NR = 2, RC = 10, DC = 10, TC = 100, CW = 16;
   localparam int RW = NR * XLEN;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   run_controller_if #(.XLEN(XLEN), .NUM_RESULTS(NR), .CNT_W(CW)) ifm ();
   run_controller_if #(.XLEN(XLEN), .NUM_RESULTS(NR), .CNT_W(CW)) ifz ();

   run_controller #(.XLEN(XLEN), .NUM_RESULTS(NR), .RESET_CYCLES(RC), .DRAIN_CYCLES(DC),
                    .TIMEOUT_CYCLES(TC), .CNT_W(CW))
      u_dut (.clk(clk), .reset(reset), .bus(ifm));

   run_controller #(.XLEN(XLEN), .NUM_RESULTS(NR), .RESET_CYCLES(RC), .DRAIN_CYCLES(0),
                    .TIMEOUT_CYCLES(TC), .CNT_W(CW))
      u_dz (.clk(clk), .reset(reset), .bus(ifz));

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      ifm.fetch_valid = 1'b0; ifm.fetch_complete = 1'b0; ifm.restart = 1'b0;
   endtask

   // Counts edges until core_reset drops (bounded).
   task automatic wait_hold(input string tag);
      int n = 0;
      while (ifm.core_reset === 1'b1 && n < 50) begin
         step();
         n++;
      end
      chk(tag, n, RC);
   endtask

   task automatic do_restart(input string tag);
      ifm.restart = 1'b1;
      step();
      ifm.restart = 1'b0;
      chk({tag, "_core_reset"}, ifm.core_reset, 1);
      chk({tag, "_done"}, ifm.done, 0);
      chk({tag, "_cycles"}, ifm.cycle_count, 0);
      chk({tag, "_instr"}, ifm.instr_count, 0);
      chk({tag, "_pc"}, ifm.last_pc, 0);
      chk({tag, "_res"}, ifm.results, 0);
      wait_hold({tag, "_hold"});
   endtask

   // Runs one program from RUN edge 0. k = completion edge (-1: never).
   // dir selects the fixed directed pattern; cut limits drain edges run.
   task automatic run_prog(input string tag, input int k, input bit dir, input int cut);
      int              e = 0;
      int              ei = 0;
      bit              fin = 0, comp = 0;
      logic            fv;
      logic [XLEN-1:0] pcv, epc = '0;
      logic [RW-1:0]   rv, eres = '0;
      while (!fin) begin
         fv  = dir ? (e < 7) : 1'($urandom_range(0, 1));
         pcv = dir ? 32'h40 : $urandom;
         rv  = dir ? 64'h0000000A_00000005 : {$urandom, $urandom};
         ifm.fetch_valid = fv; ifm.fetch_complete = (e == k); ifm.pc = pcv;
         ifm.result_in = rv; ifm.restart = dir ? 1'b0 : 1'($urandom_range(0, 1));
         step();
         if (fv) ei++;
         if (e == k) begin comp = 1; fin = 1; epc = pcv; end
         else if (e == TC - 1) begin fin = 1; epc = pcv; end
         e++;
      end
      if (comp) begin
         for (int d = 0; d < DC && d < cut; d++) begin
            rv = dir ? 64'h0000000A_00000005 : {$urandom, $urandom};
            ifm.result_in = rv; ifm.fetch_complete = 1'($urandom_range(0, 1));
            ifm.fetch_valid = 1'b1; ifm.restart = dir ? 1'b0 : 1'($urandom_range(0, 1));
            step();
            if (d == DC - 1) eres = rv;
            if (d == DC - 2) chk({tag, "_done_early"}, ifm.done, 0);
         end
      end
      clr_in();
      if (comp && cut < DC) return;
      chk({tag, "_done"}, ifm.done, comp);
      chk({tag, "_tmo"}, ifm.timed_out, !comp);
      chk({tag, "_cycles"}, ifm.cycle_count, comp ? k + 1 + DC : TC);
      chk({tag, "_instr"}, ifm.instr_count, ei);
      chk({tag, "_pc"}, ifm.last_pc, epc);
      chk({tag, "_res"}, ifm.results, eres);
      ifm.result_in = '1;
      step();
      chk({tag, "_frozen_cyc"}, ifm.cycle_count, comp ? k + 1 + DC : TC);
      chk({tag, "_frozen_res"}, ifm.results, eres);
   endtask

   initial begin
      reset = 1'b1;
      ifm.fetch_valid = 1'b1; ifm.fetch_complete = 1'b1; ifm.restart = 1'b0;
      ifm.pc = '1; ifm.result_in = '1;
      ifz.fetch_valid = 1'b0; ifz.fetch_complete = 1'b0; ifz.restart = 1'b0;
      ifz.pc = '0; ifz.result_in = '0;
      repeat (3) step();
      chk("rst_core_reset", ifm.core_reset, 1);
      chk("rst_done", ifm.done, 0);
      chk("rst_tmo", ifm.timed_out, 0);
      chk("rst_cycles", ifm.cycle_count, 0);
      chk("rst_instr", ifm.instr_count, 0);
      chk("rst_pc", ifm.last_pc, 0);
      chk("rst_res", ifm.results, 0);
      chk("rst_state", u_dut.r_state, 0);

      // fetch inputs stay high through HOLD and must be ignored
      reset = 1'b0;
      wait_hold("hold_len");
      chk("run_start_cycles", ifm.cycle_count, 0);
      chk("run_start_instr", ifm.instr_count, 0);
      chk("run_start_tmo", ifm.timed_out, 0);

      run_prog("dir", 19, 1'b1, DC);
      do_restart("rs_done");
      for (int i = 0; i < 3; i++) begin
         run_prog("rnd", int'($urandom_range(0, 98)), 1'b0, DC);
         do_restart("rs_rnd");
      end
      run_prog("tmo", -1, 1'b0, DC);
      do_restart("rs_tmo");
      run_prog("k99", 99, 1'b0, DC);
      do_restart("rs_k99");

      run_prog("cut", 5, 1'b0, 3);
      reset = 1'b1;
      #1;
      chk("mid_core_reset", ifm.core_reset, 1);
      chk("mid_done", ifm.done, 0);
      chk("mid_cycles", ifm.cycle_count, 0);
      chk("mid_instr", ifm.instr_count, 0);
      chk("mid_pc", ifm.last_pc, 0);
      chk("mid_res", ifm.results, 0);
      step();
      reset = 1'b0;
      wait_hold("hold_after_rst");

      // zero-drain instance: done on the edge after fetch_complete
      repeat (4) step();
      chk("z_done_pre", ifz.done, 0);
      ifz.pc = 32'h1234; ifz.result_in = 64'hDEAD_BEEF_0BAD_F00D; ifz.fetch_complete = 1'b1;
      step();
      ifz.fetch_complete = 1'b0;
      chk("z_done", ifz.done, 1);
      chk("z_cycles", ifz.cycle_count, 5);
      chk("z_pc", ifz.last_pc, 32'h1234);
      chk("z_res", ifz.results, 64'hDEAD_BEEF_0BAD_F00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
